bus_io_ctrl: RTL and testbench

Parametrised bidirectional bus-cycle controller for multiplexed address/data peripherals such as an external RTC. Takes a single-cycle read or write request from the host FSM and runs a complete two-phase bus cycle on a tristate port: address phase, turnaround, then data phase. Generates the chip-select and strobe signals with programmable phase length. Returns captured read data with a done pulse, and replaces the fixed 8-bit, strobe-less direct I/O block.

---
 rtl/bus_io_ctrl.sv | 151 +++++++++++++++
 tb/tb_bus_io_ctrl.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/bus_io_ctrl.sv
// bus_io_ctrl: two-phase multiplexed address/data bus cycle controller.
// Runs address, turnaround and data phases on a shared tristate port.
module bus_io_ctrl #(
  parameter int DATA_W    = 8,
  parameter int PHASE_CYC = 4,
  parameter int TURN_CYC  = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              rw,
  input  logic [DATA_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] rdata,
  output logic              cs_n,
  output logic              ad_n,
  output logic              rd_n,
  output logic              wr_n,
  inout  wire  [DATA_W-1:0] io_port
);

  localparam int MAXC = (PHASE_CYC > TURN_CYC) ? PHASE_CYC : TURN_CYC;
  localparam int CW   = $clog2(MAXC + 1);
  localparam logic [CW-1:0] PH_LD = CW'(PHASE_CYC - 1);
  localparam logic [CW-1:0] TN_LD =
    CW'((TURN_CYC > 0) ? TURN_CYC - 1 : 0);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_AHOLD, S_TURN,
    S_DATA, S_DHOLD, S_DONE
  } state_t;

  state_t            r_state;
  state_t            w_nxt;
  logic [CW-1:0]     r_cnt;
  logic [CW-1:0]     w_cnt;
  logic              r_rw;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_dout;
  logic [DATA_W-1:0] r_rdata;
  logic              r_busy;
  logic              r_done;
  logic              r_cs_n;
  logic              r_ad_n;
  logic              r_rd_n;
  logic              r_wr_n;
  logic              r_oe;
  logic              w_cs_n;
  logic              w_ad_n;
  logic              w_rd_n;
  logic              w_wr_n;
  logic              w_oe;

  always_comb begin
    w_nxt = r_state;
    unique case (r_state)
      S_IDLE:  if (start) w_nxt = S_ADDR;
      S_ADDR:  if (r_cnt == '0) w_nxt = S_AHOLD;
      S_AHOLD: w_nxt = (TURN_CYC > 0) ? S_TURN : S_DATA;
      S_TURN:  if (r_cnt == '0) w_nxt = S_DATA;
      S_DATA:  if (r_cnt == '0) w_nxt = S_DHOLD;
      S_DHOLD: w_nxt = S_DONE;
      S_DONE:  w_nxt = S_IDLE;
      default: w_nxt = S_IDLE;
    endcase
  end

  // Counter reloads on every state change, then counts down to zero.
  always_comb begin
    w_cnt = r_cnt;
    if (w_nxt != r_state)
      w_cnt = (w_nxt == S_TURN) ? TN_LD : PH_LD;
    else if (r_cnt != '0)
      w_cnt = r_cnt - 1'b1;
  end

  // Pin values for the state being entered; registered below.
  always_comb begin
    w_cs_n = 1'b1;
    w_ad_n = 1'b1;
    w_rd_n = 1'b1;
    w_wr_n = 1'b1;
    w_oe   = 1'b0;
    unique case (w_nxt)
      S_ADDR: begin
        w_cs_n = 1'b0;
        w_ad_n = 1'b0;
        w_wr_n = 1'b0;
        w_oe   = 1'b1;
      end
      S_AHOLD: w_oe = 1'b1;
      S_TURN, S_DHOLD: w_oe = !r_rw;
      S_DATA: begin
        w_cs_n = 1'b0;
        w_rd_n = !r_rw;
        w_wr_n = r_rw;
        w_oe   = !r_rw;
      end
      default: w_oe = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_rw    <= 1'b0;
      r_wdata <= '0;
      r_dout  <= '0;
      r_rdata <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_cs_n  <= 1'b1;
      r_ad_n  <= 1'b1;
      r_rd_n  <= 1'b1;
      r_wr_n  <= 1'b1;
      r_oe    <= 1'b0;
    end else begin
      r_state <= w_nxt;
      r_cnt   <= w_cnt;
      r_busy  <= (w_nxt != S_IDLE);
      r_done  <= (w_nxt == S_DONE);
      r_cs_n  <= w_cs_n;
      r_ad_n  <= w_ad_n;
      r_rd_n  <= w_rd_n;
      r_wr_n  <= w_wr_n;
      r_oe    <= w_oe;
      if (r_state == S_IDLE && start) begin
        r_rw    <= rw;
        r_wdata <= wdata;
        r_dout  <= addr;
      end
      if (r_state == S_AHOLD)
        r_dout <= r_wdata;
      if (r_state == S_DATA && r_cnt == '0 && r_rw)
        r_rdata <= io_port;
    end
  end

  assign io_port = r_oe ? r_dout : {DATA_W{1'bz}};
  assign busy    = r_busy;
  assign done    = r_done;
  assign rdata   = r_rdata;
  assign cs_n    = r_cs_n;
  assign ad_n    = r_ad_n;
  assign rd_n    = r_rd_n;
  assign wr_n    = r_wr_n;

endmodule

// File: tb/tb_bus_io_ctrl.sv
// tb_bus_io_ctrl: directed and random bus cycles against a positional
// model; a weak keeper drives 0 where the controller must release the bus.
module tb_bus_io_ctrl;

  localparam int P = 4;
  localparam int T = 1;
  localparam int L = 2 * P + T + 3;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic       start = 1'b0;
  logic       rw = 1'b0;
  logic [7:0] addr = '0;
  logic [7:0] wdata = '0;
  logic       busy, done, cs_n, ad_n, rd_n, wr_n;
  logic [7:0] rdata;
  wire  [7:0] io_port;
  logic       r_keep = 1'b1;
  logic [7:0] r_rdval = '0;

  assign io_port = !rd_n ? r_rdval : (r_keep ? 8'h00 : 8'hzz);

  bus_io_ctrl u_dut (
    .clk(clk), .reset_n(reset_n), .start(start), .rw(rw),
    .addr(addr), .wdata(wdata), .busy(busy), .done(done),
    .rdata(rdata), .cs_n(cs_n), .ad_n(ad_n), .rd_n(rd_n),
    .wr_n(wr_n), .io_port(io_port)
  );

  logic        start2 = 1'b0;
  logic        rw2 = 1'b0;
  logic [15:0] addr2 = '0;
  logic [15:0] wdata2 = '0;
  logic        busy2, done2, cs2_n, ad2_n, rd2_n, wr2_n;
  logic [15:0] rdata2;
  wire  [15:0] io2;
  logic        r_keep2 = 1'b1;

  assign io2 = !rd2_n ? 16'hBEEF : (r_keep2 ? 16'h0000 : 16'hzzzz);

  bus_io_ctrl #(.DATA_W(16), .PHASE_CYC(1), .TURN_CYC(0)) u_dut2 (
    .clk(clk), .reset_n(reset_n), .start(start2), .rw(rw2),
    .addr(addr2), .wdata(wdata2), .busy(busy2), .done(done2),
    .rdata(rdata2), .cs_n(cs2_n), .ad_n(ad2_n), .rd_n(rd2_n),
    .wr_n(wr2_n), .io_port(io2)
  );

  int errors = 0;
  int checks = 0;
  logic [7:0] m_rdata = '0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // 0 ADDR, 1 AHOLD, 2 TURN, 3 DATA, 4 DHOLD, 5 DONE by cycle position.
  function automatic int phase_of(input int k, input int p, input int t);
    if (k <= p) return 0;
    if (k == p + 1) return 1;
    if (k <= p + 1 + t) return 2;
    if (k <= 2 * p + 1 + t) return 3;
    if (k == 2 * p + t + 2) return 4;
    return 5;
  endfunction

  task automatic idle_chk();
    @(posedge clk);
    #1 r_keep = 1'b1;
    @(negedge clk);
    chk("idle_busy", busy, 0);
    chk("idle_io", io_port, 8'h00);
  endtask

  task automatic run(input bit rd, input logic [7:0] a, input logic [7:0] wd,
                     input logic [7:0] rv, input int exp_gap);
    int gap;
    int ph;
    logic [7:0] old;
    logic [7:0] eio;
    old = m_rdata;
    start = 1'b1;
    rw = rd;
    addr = a;
    wdata = wd;
    r_rdval = rv;
    gap = 0;
    @(posedge clk);
    #1;
    while (!busy && gap < 4) begin
      gap++;
      @(posedge clk);
      #1;
    end
    chk("accept_gap", gap, exp_gap);
    for (int k = 1; k <= L; k++) begin
      if (k > 1) begin
        @(posedge clk);
        #1;
      end
      start = 1'($urandom_range(0, 1));
      rw = 1'($urandom_range(0, 1));
      addr = 8'($urandom);
      wdata = 8'($urandom);
      ph = phase_of(k, P, T);
      r_keep = (ph == 5) || (rd && (ph == 2 || ph == 4));
      case (ph)
        0, 1: eio = a;
        2, 4: eio = rd ? 8'h00 : wd;
        3: eio = rd ? rv : wd;
        default: eio = 8'h00;
      endcase
      @(negedge clk);
      chk("cs_n", cs_n, !(ph == 0 || ph == 3));
      chk("ad_n", ad_n, !(ph == 0));
      chk("rd_n", rd_n, !(ph == 3 && rd));
      chk("wr_n", wr_n, !(ph == 0 || (ph == 3 && !rd)));
      chk("done", done, ph == 5);
      chk("busy", busy, 1);
      chk("io_port", io_port, eio);
      chk("rdata", rdata, (rd && ph >= 4) ? rv : old);
    end
    if (rd) m_rdata = rv;
    start = 1'b0;
  endtask

  initial begin
    int ph;
    bit chain;
    logic [15:0] e2;
    start = 1'b1;
    rw = 1'b1;
    addr = 8'($urandom);
    wdata = 8'($urandom);
    repeat (2) @(negedge clk);
    chk("rst_cs_n", cs_n, 1);
    chk("rst_ad_n", ad_n, 1);
    chk("rst_rd_n", rd_n, 1);
    chk("rst_wr_n", wr_n, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_rdata", rdata, 8'h00);
    chk("rst_io", io_port, 8'h00);
    start = 1'b0;
    reset_n = 1'b1;
    @(negedge clk);

    run(1'b0, 8'h21, 8'h5A, 8'h00, 0);
    idle_chk();
    run(1'b1, 8'h10, 8'h00, 8'hA7, 0);
    idle_chk();

    run(1'b1, 8'h3C, 8'h11, 8'h96, 0);
    run(1'b0, 8'h4D, 8'hC3, 8'h00, 1);
    idle_chk();

    start = 1'b1;
    rw = 1'b1;
    addr = 8'h33;
    r_rdval = 8'h5C;
    r_keep = 1'b0;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (P + T + 2) @(posedge clk);
    #2;
    chk("mid_rd_n", rd_n, 0);
    r_keep = 1'b1;
    reset_n = 1'b0;
    m_rdata = 8'h00;
    #1;
    chk("mid_cs_n", cs_n, 1);
    chk("mid_rd_n_rst", rd_n, 1);
    chk("mid_wr_n", wr_n, 1);
    chk("mid_ad_n", ad_n, 1);
    chk("mid_busy", busy, 0);
    chk("mid_rdata", rdata, 8'h00);
    chk("mid_io", io_port, 8'h00);
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < L + 2; i++) begin
      @(negedge clk);
      chk("post_rst_done", done, 0);
      chk("post_rst_busy", busy, 0);
    end
    run(1'b1, 8'h66, 8'h00, 8'h29, 0);

    for (int i = 0; i < 6; i++) begin
      chain = 1'($urandom_range(0, 1));
      if (!chain) idle_chk();
      run(1'($urandom_range(0, 1)), 8'($urandom_range(0, 254)),
          8'($urandom_range(1, 254)), 8'($urandom_range(1, 255)),
          chain ? 1 : 0);
    end
    idle_chk();

    start2 = 1'b1;
    rw2 = 1'b1;
    addr2 = 16'h1234;
    @(posedge clk);
    for (int k = 1; k <= 6; k++) begin
      #1;
      start2 = 1'b0;
      addr2 = 16'($urandom);
      ph = (k <= 5) ? phase_of(k, 1, 0) : 6;
      r_keep2 = !(ph == 0 || ph == 1);
      e2 = (ph <= 1) ? 16'h1234 : (ph == 3 ? 16'hBEEF : 16'h0000);
      @(negedge clk);
      chk("w16_ad_n", ad2_n, !(ph == 0));
      chk("w16_rd_n", rd2_n, !(ph == 3));
      chk("w16_cs_n", cs2_n, !(ph == 0 || ph == 3));
      chk("w16_done", done2, ph == 5);
      chk("w16_busy", busy2, ph <= 5);
      chk("w16_io", io2, e2);
      chk("w16_rdata", rdata2, ph >= 4 ? 16'hBEEF : 16'h0000);
      @(posedge clk);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
